// File: rtl/lc3_regfile.sv
// LC-3 general-purpose register file (R0..R(NREGS-1)) with NZP condition codes.
// Reads are combinational from stored state; writes and NZP updates land on the clock edge.
module lc3_regfile #(
  parameter  int WIDTH = 16,
  parameter  int NREGS = 8,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bus,
  input  logic             ld_reg,
  input  logic [AW-1:0]    dr,
  input  logic             ld_cc,
  input  logic [AW-1:0]    sr1,
  input  logic [AW-1:0]    sr2,
  output logic [WIDTH-1:0] sr1_out,
  output logic [WIDTH-1:0] sr2_out,
  output logic             n,
  output logic             z,
  output logic             p
);

  logic [WIDTH-1:0] regs [NREGS];

  // Per-register decode: a dr with no matching register (non power-of-2 NREGS) writes nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (ld_reg) begin
      for (int unsigned i = 0; i < NREGS; i++)
        if (dr == AW'(i)) regs[i] <= bus;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n <= 1'b0;
      z <= 1'b1;
      p <= 1'b0;
    end else if (ld_cc) begin
      n <= bus[WIDTH-1];
      z <= (bus == '0);
      p <= !bus[WIDTH-1] && (bus != '0);
    end
  end

  // No write-to-read bypass: ports always show the pre-edge register contents.
  always_comb begin
    sr1_out = '0;
    sr2_out = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (sr1 == AW'(i)) sr1_out = regs[i];
      if (sr2 == AW'(i)) sr2_out = regs[i];
    end
  end

  bus_driven_on_load: assert property (@(posedge clk) (ld_reg | ld_cc) |-> !$isunknown(bus));

endmodule

// File: tb/tb_lc3_regfile.sv
// Bench for lc3_regfile: directed vector table, full read-pair sweep, then random traffic
// against an array-based reference model.
module tb_lc3_regfile;

  logic        clk = 1'b0;
  logic        rst, ld_reg, ld_cc;
  logic [2:0]  dr, sr1, sr2;
  logic [15:0] bus, sr1_out, sr2_out;
  logic        n, z, p;

  int total = 0;
  int bad   = 0;

  lc3_regfile #(.WIDTH(16), .NREGS(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .ld_reg(ld_reg), .dr(dr), .ld_cc(ld_cc),
    .sr1(sr1), .sr2(sr2), .sr1_out(sr1_out), .sr2_out(sr2_out), .n(n), .z(z), .p(p)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, ld_reg, ld_cc, chk;
    logic [2:0]  dr, sr1, sr2;
    logic [15:0] bus, e1, e2;
    logic [2:0]  enzp;
  } vec_t;

  // Reference model: plain array of register values and an NZP triple.
  logic [15:0] m_r [8];
  logic [2:0]  m_nzp;
  bit          m_valid = 1'b0;

  function automatic logic [2:0] cc_of(input logic [15:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == 16'd0)     return 3'b010;
    return 3'b001;
  endfunction

  function automatic vec_t mk(input logic r, ldr, ldc, input logic [2:0] d, s1, s2,
                              input logic [15:0] b, input logic c,
                              input logic [15:0] x1, x2, input logic [2:0] xc);
    vec_t v;
    v.rst = r; v.ld_reg = ldr; v.ld_cc = ldc; v.dr = d; v.sr1 = s1; v.sr2 = s2;
    v.bus = b; v.chk = c; v.e1 = x1; v.e2 = x2; v.enzp = xc;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs, check outputs before the edge, then advance the model.
  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    rst = v.rst; ld_reg = v.ld_reg; ld_cc = v.ld_cc;
    dr = v.dr; sr1 = v.sr1; sr2 = v.sr2; bus = v.bus;
    #1;
    if (v.chk) begin
      cmp({tag, " tbl sr1"}, sr1_out, v.e1);
      cmp({tag, " tbl sr2"}, sr2_out, v.e2);
      cmp({tag, " tbl nzp"}, {13'd0, n, z, p}, {13'd0, v.enzp});
    end
    if (m_valid) begin
      cmp({tag, " mdl sr1"}, sr1_out, m_r[v.sr1]);
      cmp({tag, " mdl sr2"}, sr2_out, m_r[v.sr2]);
      cmp({tag, " mdl nzp"}, {13'd0, n, z, p}, {13'd0, m_nzp});
      cmp({tag, " onehot"}, {15'd0, $onehot({n, z, p})}, 16'd1);
    end
    @(posedge clk);
    if (v.rst) begin
      for (int i = 0; i < 8; i++) m_r[i] = 16'd0;
      m_nzp   = 3'b010;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (v.ld_reg) m_r[v.dr] = v.bus;
      if (v.ld_cc)  m_nzp = cc_of(v.bus);
    end
  endtask

  vec_t tbl [12];
  vec_t v;

  initial begin
    rst = 1'b0; ld_reg = 1'b0; ld_cc = 1'b0; dr = '0; sr1 = '0; sr2 = '0; bus = '0;

    //          rst ldr ldc dr sr1 sr2 bus        chk e1        e2        nzp
    tbl[0]  = mk(1, 1, 1, 2, 0, 0, 16'hFFFF, 0, 16'h0000, 16'h0000, 3'b010);
    tbl[1]  = mk(0, 0, 0, 0, 0, 7, 16'h0000, 1, 16'h0000, 16'h0000, 3'b010);
    tbl[2]  = mk(0, 1, 0, 3, 3, 3, 16'h1234, 1, 16'h0000, 16'h0000, 3'b010);
    tbl[3]  = mk(0, 0, 0, 0, 3, 0, 16'h0000, 1, 16'h1234, 16'h0000, 3'b010);
    tbl[4]  = mk(0, 0, 1, 0, 3, 2, 16'h8000, 1, 16'h1234, 16'h0000, 3'b010);
    tbl[5]  = mk(0, 0, 1, 0, 0, 3, 16'h0000, 1, 16'h0000, 16'h1234, 3'b100);
    tbl[6]  = mk(0, 0, 1, 0, 0, 0, 16'h0001, 1, 16'h0000, 16'h0000, 3'b010);
    tbl[7]  = mk(0, 1, 0, 1, 0, 0, 16'h0005, 1, 16'h0000, 16'h0000, 3'b001);
    tbl[8]  = mk(0, 1, 1, 1, 1, 1, 16'h000A, 1, 16'h0005, 16'h0005, 3'b001);
    tbl[9]  = mk(0, 0, 0, 0, 1, 1, 16'h0000, 1, 16'h000A, 16'h000A, 3'b001);
    tbl[10] = mk(1, 1, 1, 1, 1, 3, 16'hFFFF, 1, 16'h000A, 16'h1234, 3'b001);
    tbl[11] = mk(0, 0, 0, 0, 1, 3, 16'h0000, 1, 16'h0000, 16'h0000, 3'b010);

    for (int i = 0; i < 12; i++) step(tbl[i], $sformatf("v%0d", i));

    // Distinct value per register, then every read-port pairing.
    for (int i = 0; i < 8; i++)
      step(mk(0, 1, 0, 3'(i), 0, 0, 16'h1111 * 16'(i + 1), 0, 0, 0, 0), $sformatf("wr%0d", i));
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        step(mk(0, 0, 0, 0, 3'(a), 3'(b), 16'h0000, 1,
                16'h1111 * 16'(a + 1), 16'h1111 * 16'(b + 1), 3'b010),
             $sformatf("pair%0d_%0d", a, b));

    for (int k = 0; k < 400; k++) begin
      v.rst    = ($urandom_range(0, 31) == 0);
      v.ld_reg = $urandom_range(0, 1);
      v.ld_cc  = $urandom_range(0, 1);
      v.dr     = 3'($urandom_range(0, 7));
      v.sr1    = 3'($urandom_range(0, 7));
      v.sr2    = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       v.bus = 16'h0000;
        1:       v.bus = 16'h8000;
        2:       v.bus = 16'h7FFF;
        3:       v.bus = 16'hFFFF;
        default: v.bus = 16'($urandom);
      endcase
      v.chk = 1'b0; v.e1 = '0; v.e2 = '0; v.enzp = '0;
      step(v, $sformatf("rnd%0d", k));
    end

    @(negedge clk);
    ld_reg = 1'b0; ld_cc = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
